// File: rtl/ttt_game_sequencer_if.sv
// Move-offer handshake plus board-memory port of the game sequencer.
// master = sequencer side, slave = front end / board memory side.
interface ttt_game_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int CELL_W = 2
);
  logic              move_valid;
  logic [ADDR_W-1:0] move_addr;
  logic              move_ready;
  logic              move_ack;
  logic              move_nack;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [CELL_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [CELL_W-1:0] mem_wr_data;

  modport master (
    input  move_valid, move_addr, mem_rd_data,
    output move_ready, move_ack, move_nack,
    output mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output move_valid, move_addr, mem_rd_data,
    input  move_ready, move_ack, move_nack,
    input  mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/ttt_game_sequencer.sv
// N-player tic-tac-toe sequencer: clear board, accept/validate/commit moves, rotate turns, declare win/draw.
// Latency: ack 2 cycles after accept, next move_ready 4 cycles after accept; CLEAR takes CELLS cycles.
// Backpressure: move_ready only in WAIT_MOVE; MOVE_TIMEOUT_EN adds a per-turn pass after TIMEOUT_CYCLES idle cycles.
module ttt_game_sequencer #(
  parameter int BOARD_DIM      = 3,
  parameter int NUM_PLAYERS    = 2,
  parameter int ADDR_W         = $clog2(BOARD_DIM*BOARD_DIM),
  parameter int PID_W          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  parameter int CELL_W         = $clog2(NUM_PLAYERS+1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 ph1,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [PID_W-1:0]     first_player,
  ttt_game_sequencer_if.master bus,
  output logic [PID_W-1:0]     cur_player,
  input  logic                 win_flag,
  output logic [ADDR_W:0]      move_count,
  output logic                 game_over,
  output logic                 draw,
  output logic [PID_W-1:0]     winner,
  output logic                 timeout_pulse
);
  localparam int CELLS = BOARD_DIM*BOARD_DIM;
  localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W+1)'(CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS-1);
  localparam logic [PID_W-1:0]  LAST_PID  = PID_W'(NUM_PLAYERS-1);
  localparam logic [PID_W:0]    NP_W      = (PID_W+1)'(NUM_PLAYERS);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 7) begin : g_bad_players
    $error("NUM_PLAYERS must be in 2..7");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_MOVE, CHECK, COMMIT, EVAL, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PID_W-1:0]  cur_player_q, cur_player_d;
  logic [PID_W-1:0]  winner_q, winner_d;
  logic [ADDR_W:0]   move_count_q, move_count_d;
  logic              game_over_q, game_over_d;
  logic              draw_q, draw_d;

  logic              restart;
  logic              bad_move;
  logic [PID_W-1:0]  next_player;
  logic [PID_W-1:0]  start_player;
  logic [PID_W:0]    pid_plus1;

`ifdef MOVE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES-1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_pulse;
`endif

  // CLEAR must finish wiping the board, so start is only honoured outside it.
  assign restart      = start && (state_q != CLEAR);
  assign next_player  = (cur_player_q == LAST_PID) ? '0 : cur_player_q + 1'b1;
  assign start_player = ({1'b0, first_player} >= NP_W) ? '0 : first_player;
  assign pid_plus1    = {1'b0, cur_player_q} + 1'b1;
  assign bad_move     = ({1'b0, addr_q} >= CELLS_W) || (bus.mem_rd_data != '0);

  // Synchronous-read memory: present the offered address while waiting so data lands in CHECK.
  assign bus.mem_rd_addr = (state_q == WAIT_MOVE) ? bus.move_addr : addr_q;
  assign bus.move_ready  = (state_q == WAIT_MOVE);

  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    addr_d          = addr_q;
    cur_player_d    = cur_player_q;
    winner_d        = winner_q;
    move_count_d    = move_count_q;
    game_over_d     = game_over_q;
    draw_d          = draw_q;
    bus.move_ack    = 1'b0;
    bus.move_nack   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
`ifdef MOVE_TIMEOUT_EN
    to_cnt_d        = '0;
    to_pulse        = 1'b0;
`endif

    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = clr_cnt_q;
        clr_cnt_d       = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_CELL) begin
          clr_cnt_d = '0;
          state_d   = WAIT_MOVE;
        end
      end
      WAIT_MOVE: begin
        if (bus.move_valid) begin
          addr_d  = bus.move_addr;
          state_d = CHECK;
        end
`ifdef MOVE_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          to_pulse     = 1'b1;
          cur_player_d = next_player;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      CHECK: begin
        if (bad_move) begin
          bus.move_nack = 1'b1;
          state_d       = WAIT_MOVE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = addr_q;
        bus.mem_wr_data = CELL_W'(pid_plus1);
        bus.move_ack    = 1'b1;
        move_count_d    = move_count_q + 1'b1;
        state_d         = EVAL;
      end
      EVAL: begin
        if (win_flag) begin
          game_over_d = 1'b1;
          winner_d    = cur_player_q;
          state_d     = DONE;
        end else if (move_count_q == CELLS_W) begin
          game_over_d = 1'b1;
          draw_d      = 1'b1;
          state_d     = DONE;
        end else begin
          cur_player_d = next_player;
          state_d      = WAIT_MOVE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the current state was about to do, including a pending commit.
    if (restart) begin
      state_d         = CLEAR;
      clr_cnt_d       = '0;
      cur_player_d    = start_player;
      winner_d        = '0;
      move_count_d    = '0;
      game_over_d     = 1'b0;
      draw_d          = 1'b0;
      bus.move_ack    = 1'b0;
      bus.move_nack   = 1'b0;
      bus.mem_wr_en   = 1'b0;
      bus.mem_wr_addr = '0;
      bus.mem_wr_data = '0;
`ifdef MOVE_TIMEOUT_EN
      to_cnt_d        = '0;
      to_pulse        = 1'b0;
`endif
    end
  end

  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      addr_q       <= '0;
      cur_player_q <= '0;
      winner_q     <= '0;
      move_count_q <= '0;
      game_over_q  <= 1'b0;
      draw_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      addr_q       <= addr_d;
      cur_player_q <= cur_player_d;
      winner_q     <= winner_d;
      move_count_q <= move_count_d;
      game_over_q  <= game_over_d;
      draw_q       <= draw_d;
    end
  end

`ifdef MOVE_TIMEOUT_EN
  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
  assign timeout_pulse = to_pulse;
`else
  assign timeout_pulse = 1'b0;
`endif

  assign cur_player = cur_player_q;
  assign winner     = winner_q;
  assign move_count = move_count_q;
  assign game_over  = game_over_q;
  assign draw       = draw_q;
endmodule

// File: tb/tb_ttt_game_sequencer.sv
// Drives a 2-player and a 3-player sequencer with identical stimulus; a board/turn model checks both every cycle.
module tb_ttt_game_sequencer;
  localparam int AW    = 4;
  localparam int CW    = 2;
  localparam int CELLS = 9;
`ifdef MOVE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 8;

  logic          ph1 = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic          move_valid = 1'b0, win_flag = 1'b0;
  logic [1:0]    first_player = 2'd0;
  logic [AW-1:0] move_addr = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ph1 = ~ph1;

  ttt_game_sequencer_if #(.ADDR_W(AW), .CELL_W(CW)) bus2 ();
  ttt_game_sequencer_if #(.ADDR_W(AW), .CELL_W(CW)) bus3 ();
  assign bus2.move_valid = move_valid;
  assign bus2.move_addr  = move_addr;
  assign bus3.move_valid = move_valid;
  assign bus3.move_addr  = move_addr;

  logic [0:0] cur2, win2;
  logic [1:0] cur3, win3;
  logic [4:0] cnt2, cnt3;
  logic       over2, over3, draw2, draw3, to2, to3;

  ttt_game_sequencer #(.NUM_PLAYERS(2), .TIMEOUT_CYCLES(TO)) u_dut2 (
    .ph1(ph1), .reset_n(reset_n), .start(start), .first_player(first_player[0:0]),
    .bus(bus2), .cur_player(cur2), .win_flag(win_flag), .move_count(cnt2),
    .game_over(over2), .draw(draw2), .winner(win2), .timeout_pulse(to2)
  );
  ttt_game_sequencer #(.NUM_PLAYERS(3), .TIMEOUT_CYCLES(TO)) u_dut3 (
    .ph1(ph1), .reset_n(reset_n), .start(start), .first_player(first_player),
    .bus(bus3), .cur_player(cur3), .win_flag(win_flag), .move_count(cnt3),
    .game_over(over3), .draw(draw3), .winner(win3), .timeout_pulse(to3)
  );

  // Board memories with one-cycle synchronous read.
  logic [CW-1:0] ram2 [16];
  logic [CW-1:0] ram3 [16];
  initial for (int k = 0; k < 16; k++) begin ram2[k] = '0; ram3[k] = '0; end
  always @(posedge ph1) begin
    if (bus2.mem_wr_en) ram2[bus2.mem_wr_addr] <= bus2.mem_wr_data;
    if (bus3.mem_wr_en) ram3[bus3.mem_wr_addr] <= bus3.mem_wr_data;
    bus2.mem_rd_data <= ram2[bus2.mem_rd_addr];
    bus3.mem_rd_data <= ram3[bus3.mem_rd_addr];
  end

  // Observed outputs gathered per instance (0 = 2 players, 1 = 3 players).
  int o_ready[2], o_ack[2], o_nack[2], o_wen[2], o_waddr[2], o_wdata[2], o_raddr[2];
  int o_cur[2], o_cnt[2], o_over[2], o_draw[2], o_win[2], o_to[2];
  always_comb begin
    o_ready[0] = int'(bus2.move_ready); o_ready[1] = int'(bus3.move_ready);
    o_ack[0]   = int'(bus2.move_ack);   o_ack[1]   = int'(bus3.move_ack);
    o_nack[0]  = int'(bus2.move_nack);  o_nack[1]  = int'(bus3.move_nack);
    o_wen[0]   = int'(bus2.mem_wr_en);  o_wen[1]   = int'(bus3.mem_wr_en);
    o_waddr[0] = int'(bus2.mem_wr_addr); o_waddr[1] = int'(bus3.mem_wr_addr);
    o_wdata[0] = int'(bus2.mem_wr_data); o_wdata[1] = int'(bus3.mem_wr_data);
    o_raddr[0] = int'(bus2.mem_rd_addr); o_raddr[1] = int'(bus3.mem_rd_addr);
    o_cur[0]   = int'(cur2);  o_cur[1]  = int'(cur3);
    o_cnt[0]   = int'(cnt2);  o_cnt[1]  = int'(cnt3);
    o_over[0]  = int'(over2); o_over[1] = int'(over3);
    o_draw[0]  = int'(draw2); o_draw[1] = int'(draw3);
    o_win[0]   = int'(win2);  o_win[1]  = int'(win3);
    o_to[0]    = int'(to2);   o_to[1]   = int'(to3);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: clearing countdown, move pipeline age after acceptance, board contents and turn order.
  int np[2] = '{2, 3};
  int clr_left, pend, tcnt, paddr, m_cnt;
  bit waiting, m_over, m_draw;
  int m_cur[2], m_win[2];
  int board[2][CELLS];

  function automatic bit occupied(input int i, input int a);
    return (a >= CELLS) ? 1'b1 : (board[i][a] != 0);
  endfunction

  always @(negedge ph1) begin
    int e_ack, e_wen, e_to, fp, e_nack;
    if (!reset_n) begin
      clr_left = 0; pend = 0; tcnt = 0; paddr = 0; m_cnt = 0;
      waiting = 0; m_over = 0; m_draw = 0;
      for (int i = 0; i < 2; i++) begin
        m_cur[i] = 0; m_win[i] = 0;
        for (int c = 0; c < CELLS; c++) board[i][c] = 0;
        chk($sformatf("rst%0d_ready", i), o_ready[i], 0);
        chk($sformatf("rst%0d_wen", i), o_wen[i], 0);
        chk($sformatf("rst%0d_cur", i), o_cur[i], 0);
        chk($sformatf("rst%0d_cnt", i), o_cnt[i], 0);
        chk($sformatf("rst%0d_over", i), o_over[i] + o_draw[i] + o_win[i], 0);
        chk($sformatf("rst%0d_acks", i), o_ack[i] + o_nack[i] + o_to[i], 0);
      end
    end else begin
      e_ack = (pend == 2 && !start) ? 1 : 0;
      e_wen = (clr_left > 0 || e_ack == 1) ? 1 : 0;
      e_to  = (TO_EN && waiting && !move_valid && !start && tcnt == TO - 1) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        e_nack = (pend == 1 && !start && occupied(i, paddr)) ? 1 : 0;
        chk($sformatf("i%0d_ready", i), o_ready[i], int'(waiting));
        chk($sformatf("i%0d_ack", i), o_ack[i], e_ack);
        chk($sformatf("i%0d_nack", i), o_nack[i], e_nack);
        chk($sformatf("i%0d_wen", i), o_wen[i], e_wen);
        chk($sformatf("i%0d_to", i), o_to[i], e_to);
        chk($sformatf("i%0d_cur", i), o_cur[i], m_cur[i]);
        chk($sformatf("i%0d_cnt", i), o_cnt[i], m_cnt);
        chk($sformatf("i%0d_over", i), o_over[i], int'(m_over));
        chk($sformatf("i%0d_draw", i), o_draw[i], int'(m_draw));
        chk($sformatf("i%0d_winner", i), o_win[i], m_win[i]);
        if (clr_left > 0) begin
          chk($sformatf("i%0d_clr_addr", i), o_waddr[i], CELLS - clr_left);
          chk($sformatf("i%0d_clr_data", i), o_wdata[i], 0);
        end else if (e_ack == 1) begin
          chk($sformatf("i%0d_wr_addr", i), o_waddr[i], paddr);
          chk($sformatf("i%0d_wr_data", i), o_wdata[i], m_cur[i] + 1);
        end
        if (waiting && move_valid && !start)
          chk($sformatf("i%0d_rd_addr", i), o_raddr[i], int'(move_addr));
      end
      // Advance the model to the state after the coming rising edge.
      if (start && clr_left == 0) begin
        clr_left = CELLS; pend = 0; waiting = 0; tcnt = 0;
        m_cnt = 0; m_over = 0; m_draw = 0;
        for (int i = 0; i < 2; i++) begin
          fp = (i == 0) ? int'(first_player[0]) : int'(first_player);
          m_cur[i] = (fp >= np[i]) ? 0 : fp;
          m_win[i] = 0;
        end
      end else if (clr_left > 0) begin
        for (int i = 0; i < 2; i++) board[i][CELLS - clr_left] = 0;
        clr_left--;
        if (clr_left == 0) waiting = 1;
      end else if (waiting) begin
        if (move_valid) begin
          paddr = int'(move_addr); pend = 1; waiting = 0;
        end else if (TO_EN) begin
          if (tcnt == TO - 1) begin
            tcnt = 0;
            for (int i = 0; i < 2; i++) m_cur[i] = (m_cur[i] + 1) % np[i];
          end else tcnt++;
        end
      end else if (pend == 1) begin
        if (occupied(0, paddr)) begin pend = 0; waiting = 1; tcnt = 0; end
        else pend = 2;
      end else if (pend == 2) begin
        for (int i = 0; i < 2; i++) board[i][paddr] = m_cur[i] + 1;
        m_cnt++; pend = 3;
      end else if (pend == 3) begin
        pend = 0;
        if (win_flag) begin
          m_over = 1;
          for (int i = 0; i < 2; i++) m_win[i] = m_cur[i];
        end else if (m_cnt == CELLS) begin
          m_over = 1; m_draw = 1;
        end else begin
          for (int i = 0; i < 2; i++) m_cur[i] = (m_cur[i] + 1) % np[i];
          waiting = 1; tcnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus2.move_ready) begin ok = 1'b1; break; end
      tick();
    end
    chk("wait_ready", int'(ok), 1);
  endtask

  // Offer a move, hold it until accepted; returns in the CHECK cycle.
  task automatic offer(input int a);
    bit ok = 1'b0;
    move_valid = 1'b1;
    move_addr  = AW'(a);
    for (int k = 0; k < 40; k++) begin
      if (bus2.move_ready) begin tick(); ok = 1'b1; break; end
      tick();
    end
    move_valid = 1'b0;
    chk($sformatf("offer_%0d_accepted", a), int'(ok), 1);
  endtask

  task automatic pulse_start(input int fp);
    first_player = 2'(fp);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int fill[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Game 1: first player 1, clear then draw.
    pulse_start(1);
    repeat (8) tick();
    chk("clr_ready_c9", int'(bus2.move_ready), 0);
    tick();
    chk("clr_ready_c10", int'(bus2.move_ready), 1);
    chk("g1_first_p2", int'(cur2), 1);
    chk("g1_first_p3", int'(cur3), 1);

    offer(4);
    tick();
    chk("m1_ack", int'(bus2.move_ack), 1);
    chk("m1_wr_addr", int'(bus2.mem_wr_addr), 4);
    chk("m1_wr_data", int'(bus2.mem_wr_data), 2);
    wait_ready();
    chk("m1_count", int'(cnt2), 1);
    chk("m1_next_p2", int'(cur2), 0);
    chk("m1_next_p3", int'(cur3), 2);

    offer(4);
    chk("occ_nack", int'(bus2.move_nack), 1);
    chk("occ_no_wr", int'(bus2.mem_wr_en), 0);
    offer(9);
    chk("oor_nack", int'(bus2.move_nack), 1);
    tick();
    chk("nack_same_player", int'(cur2), 0);

    foreach (fill[k]) offer(fill[k]);
    repeat (3) tick();
    chk("draw_over", int'(over2), 1);
    chk("draw_flag", int'(draw2), 1);
    chk("draw_count", int'(cnt2), 9);
    chk("draw_ready", int'(bus2.move_ready), 0);

    // Game 2: first_player 3 is out of range for 3 players; third move wins.
    pulse_start(3);
    wait_ready();
    chk("g2_first_p3", int'(cur3), 0);
    chk("g2_first_p2", int'(cur2), 1);
    offer(0);
    wait_ready();
    chk("g2_turn_p3_1", int'(cur3), 1);
    offer(4);
    wait_ready();
    chk("g2_turn_p3_2", int'(cur3), 2);
    win_flag = 1'b1;
    offer(8);
    repeat (3) tick();
    win_flag = 1'b0;
    chk("win_over", int'(over3), 1);
    chk("win_nodraw", int'(draw3), 0);
    chk("win_p3", int'(win3), 2);
    chk("win_p2", int'(win2), 1);
    chk("win_count", int'(cnt3), 3);

    // Game 3: start during CLEAR is ignored, then abort in CHECK.
    pulse_start(0);
    repeat (2) tick();
    pulse_start(1);
    repeat (5) tick();
    chk("clr_ignore_c9", int'(bus2.move_ready), 0);
    tick();
    chk("clr_ignore_c10", int'(bus2.move_ready), 1);
    chk("clr_ignore_player", int'(cur2), 0);
    offer(0);
    wait_ready();
    offer(5);
    pulse_start(0);
    chk("abort_no_ack", int'(bus2.move_ack), 0);
    chk("abort_clear_addr", int'(bus2.mem_wr_addr), 0);
    chk("abort_count", int'(cnt2), 0);
    wait_ready();
    chk("abort_count_after", int'(cnt3), 0);

`ifdef MOVE_TIMEOUT_EN
    repeat (7) tick();
    chk("to_pulse", int'(to2), 1);
    tick();
    chk("to_player_p2", int'(cur2), 1);
    chk("to_player_p3", int'(cur3), 1);
    chk("to_count", int'(cnt2), 0);
`else
    repeat (12) tick();
    chk("no_to_player", int'(cur2), 0);
    chk("no_to_pulse", int'(to2), 0);
`endif
    offer(2);
    tick();
    chk("post_ack", int'(bus3.move_ack), 1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
